linear_layer_i4xi4_q_start_token_reader: RTL

LINEAR_LAYER_I4XI4_Q_START_TOKEN_READER -- requirements
Module: linear_layer_i4xi4_q_start_token_reader

---
 rtl/linear_layer_q_ctrl_pkg.sv | 18 +
 rtl/linear_layer_q_outstanding_cnt.sv | 47 ++++
 rtl/linear_layer_i4xi4_q_start_token_reader.sv | 64 ++++++
 3 files changed

// File: rtl/linear_layer_q_ctrl_pkg.sv
// Shared control types and default widths for the linear-layer start-token readers.
package linear_layer_q_ctrl_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_START = 1'b1
  } q_state_e;

  localparam int DEF_DATA_WIDTH      = 1;
  localparam int DEF_MAX_OUTSTANDING = 2;
  localparam int DEF_CNT_WIDTH       = 16;

  // Bits needed to hold 0..max inclusive.
  function automatic int cnt_bits(input int max);
    return (max < 2) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/linear_layer_q_outstanding_cnt.sv
// Up/down count of PE iterations started but not yet done, with admission and underflow.
module linear_layer_q_outstanding_cnt
  import linear_layer_q_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_hs,
  input  logic done,
  output logic room,
  output logic nz_next,
  output logic err_underflow
);

  localparam int OW = cnt_bits(MAX_OUTSTANDING);
  localparam logic [OW:0] MAX_V = (OW+1)'(MAX_OUTSTANDING);

  logic [OW-1:0] outstanding;
  logic [OW:0]   nxt;
  logic          underflow;

  assign underflow = done & ~start_hs & (outstanding == '0);

  // A done against an empty count is flagged, never allowed to wrap the count.
  always_comb begin
    nxt = {1'b0, outstanding};
    if (start_hs && !done)
      nxt = nxt + (OW+1)'(1);
    else if (done && !start_hs && outstanding != '0)
      nxt = nxt - (OW+1)'(1);
  end

  assign room    = (nxt < MAX_V);
  assign nz_next = (nxt != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else begin
      outstanding <= nxt[OW-1:0];
      if (underflow) err_underflow <= 1'b1;
    end
  end

endmodule

// File: rtl/linear_layer_i4xi4_q_start_token_reader.sv
// Pops start tokens from a FIFO and issues ap_ctrl_hs starts to a PE, bounded by outstanding work.
module linear_layer_i4xi4_q_start_token_reader
  import linear_layer_q_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  if_empty_n,
  output logic                  if_read,
  input  logic [DATA_WIDTH-1:0] if_dout,
  output logic                  pe_ap_start,
  input  logic                  pe_ap_ready,
  input  logic                  pe_ap_done,
  output logic [DATA_WIDTH-1:0] pe_token,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  done_count,
  output logic                  err_underflow
);

  q_state_e state, state_nxt;
  logic     start_hs, room, nz_next;

  assign pe_ap_start = ap_rst_n & (state == S_START);
  assign start_hs    = pe_ap_start & pe_ap_ready;

  // Pop only when the held token is free (idle, or leaving this cycle) and the count admits it.
  assign if_read = ap_rst_n & if_empty_n & room & ((state == S_IDLE) | start_hs);

  always_comb begin
    state_nxt = state;
    if (if_read)       state_nxt = S_START;
    else if (start_hs) state_nxt = S_IDLE;
  end

  linear_layer_q_outstanding_cnt #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_cnt (
    .clk          (ap_clk),
    .rst_n        (ap_rst_n),
    .start_hs     (start_hs),
    .done         (pe_ap_done),
    .room         (room),
    .nz_next      (nz_next),
    .err_underflow(err_underflow)
  );

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state      <= S_IDLE;
      pe_token   <= '0;
      done_count <= '0;
      busy       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (if_read)    pe_token   <= if_dout;
      if (pe_ap_done) done_count <= done_count + CNT_WIDTH'(1);
      busy <= (state_nxt == S_START) | nz_next;
    end
  end

endmodule
